pipe_hazard_ctrl: RTL

Hazard and sequencing controller for the five-stage pipeline. It drives the decode-stage register's write enable (`wpcir`) and inserts bubbles into execute. It generates the operand forwarding selects for the decode-stage operands, and sequences the multi-cycle multiply/divide unit (MDU), stalling decode while the MDU is occupied. It sits beside the decode register, taking decoded register numbers from decode and destination information from the execute and memory stages.

---
 rtl/pipe_ctrl_pkg.sv | 34 +++
 rtl/md_seq.sv | 63 ++++++
 rtl/pipe_hazard_ctrl.sv | 81 ++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select
// codes, the MDU sequencer state encoding and the forwarding priority rule.
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_EALU = 2'b01;
  localparam logic [1:0] FWD_MALU = 2'b10;
  localparam logic [1:0] FWD_MMEM = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  // Execute wins over memory; a load in execute cannot forward (load-use stalls instead).
  function automatic logic [1:0] fwd_sel(
    input logic       ewreg,
    input logic       em2reg,
    input logic [4:0] ern,
    input logic       mwreg,
    input logic       mm2reg,
    input logic [4:0] mrn,
    input logic [4:0] src
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (ewreg && !em2reg && (ern != 5'd0) && (ern == src))
      sel = FWD_EALU;
    else if (mwreg && (mrn != 5'd0) && (mrn == src))
      sel = mm2reg ? FWD_MMEM : FWD_MALU;
    return sel;
  endfunction

endpackage

// File: rtl/md_seq.sv
// MDU sequencer: launches an operation and keeps the unit busy for
// MD_CYCLES cycles, flagging the final busy cycle with md_done.
module md_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic launch,
  output logic md_start,
  output logic md_busy,
  output logic md_done
);

  localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 1);

  md_state_t  state_reg;
  logic [7:0] cnt_reg;
  logic       md_busy_reg;
  logic       md_done_reg;

  assign md_start = !reset && (state_reg == IDLE) && launch;
  assign md_busy  = md_busy_reg;
  assign md_done  = md_done_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= 8'd0;
      md_busy_reg <= 1'b0;
      md_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (md_start) begin
            state_reg   <= BUSY;
            cnt_reg     <= MD_LOAD;
            md_busy_reg <= 1'b1;
            md_done_reg <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt_reg == 8'd0) begin
            state_reg   <= IDLE;
            md_busy_reg <= 1'b0;
            md_done_reg <= 1'b0;
          end else begin
            // done is registered, so it is raised one count early to land on cnt==0
            cnt_reg     <= cnt_reg - 8'd1;
            md_done_reg <= (cnt_reg == 8'd1);
          end
        end
        default: begin
          state_reg   <= IDLE;
          md_busy_reg <= 1'b0;
          md_done_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the five-stage pipeline: operand forwarding,
// load-use and MDU structural stalls, MDU sequencing and stall statistics.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             d_use_rs,
  input  logic             d_use_rt,
  input  logic             d_md_op,
  input  logic             d_md_read,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       ern,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic [4:0]       mrn,
  output logic             wpcir,
  output logic             ebubble,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [4:0]       src [2];
  logic [1:0]       fwd [2];
  logic             lu;
  logic             st;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt_reg;

  assign src[0] = rs;
  assign src[1] = rt;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd[gi] = reset ? FWD_RF
                             : fwd_sel(ewreg, em2reg, ern, mwreg, mm2reg, mrn, src[gi]);
    end
  endgenerate

  assign fwda = fwd[0];
  assign fwdb = fwd[1];

  assign lu = ewreg && em2reg && (ern != 5'd0) &&
              ((d_use_rs && (ern == rs)) || (d_use_rt && (ern == rt)));
  assign st    = md_busy && (d_md_op || d_md_read);
  assign stall = lu || st;

  assign wpcir   = reset || !stall;
  assign ebubble = !reset && stall;

  md_seq #(
    .MD_CYCLES(MD_CYCLES)
  ) u_md_seq (
    .clock    (clock),
    .reset    (reset),
    .launch   (d_md_op && !stall),
    .md_start (md_start),
    .md_busy  (md_busy),
    .md_done  (md_done)
  );

  always_ff @(posedge clock) begin
    if (reset)
      stall_cnt_reg <= '0;
    else if (!wpcir && (stall_cnt_reg != {CNT_W{1'b1}}))
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
  end

  assign stall_cnt = stall_cnt_reg;

endmodule
